regfile_onehot_wr: RTL and testbench

//  - Architectural integer register file for the pipelined ARM core (write-back consumer side).
//  - Takes the one-hot write-select vector from the write-address decoder, plus WB data.
//  - Provides two combinational read ports to the decode/operand-fetch stage.
//  - Register NUM_REGS-1 (X31/XZR) is hardwired to zero.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/register_en.sv | 34 +++
 rtl/regfile_onehot_wr.sv | 75 +++++++
 tb/tb_regfile_onehot_wr.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizes and bus types for the architectural integer register file.
package regfile_pkg;

    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned ADDR_W     = $clog2(NUM_REGS);
    localparam int unsigned ZERO_REG   = NUM_REGS - 1;

    typedef logic [ADDR_W-1:0]     reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;
    typedef logic [NUM_REGS-1:0]   reg_sel_t;

endpackage

// File: rtl/register_en.sv
// Single architectural register: load-enabled flop with asynchronous active-high clear.
module register_en
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/regfile_onehot_wr.sv
// Integer register file: one-hot write port, two combinational read ports, top entry hardwired to zero.
// Define REGFILE_WR_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_onehot_wr #(
    parameter  int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter  int unsigned NUM_REGS   = regfile_pkg::NUM_REGS,
    localparam int unsigned ADDR_W     = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [NUM_REGS-1:0]   wr_sel,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr1,
    input  logic [ADDR_W-1:0]     rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2
);

    localparam int unsigned ZERO_REG = NUM_REGS - 1;

    if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
        $error("regfile_onehot_wr: NUM_REGS must be a power of two >= 2");
    end

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [ADDR_W-1:0]     rd_addr [2];
    logic [DATA_WIDTH-1:0] rd_data [2];
    logic                  unused_zero_sel;

    // The zero register has no storage, so its select bit has no load to drive.
    assign unused_zero_sel = wr_sel[ZERO_REG];

    for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_reg
        register_en #(
            .WIDTH (DATA_WIDTH)
        ) u_reg (
            .clk   (clk),
            .reset (reset),
            .load  (wr_en & wr_sel[i]),
            .d     (wr_data),
            .q     (regs[i])
        );
    end

    assign regs[ZERO_REG] = '0;

    assign rd_addr[0] = rd_addr1;
    assign rd_addr[1] = rd_addr2;
    assign rd_data1   = rd_data[0];
    assign rd_data2   = rd_data[1];

    for (genvar p = 0; p < 2; p++) begin : g_port
        // Heap-ordered 2:1 mux tree: node 1 is the root, leaves start at NUM_REGS.
        logic [DATA_WIDTH-1:0] node [1:2*NUM_REGS-1];

        for (genvar n = 1; n < 2 * NUM_REGS; n++) begin : g_node
            if (n >= NUM_REGS) begin : g_leaf
                assign node[n] = regs[n - NUM_REGS];
            end else begin : g_mux
                localparam int unsigned LVL = $clog2(n + 1) - 1;
                assign node[n] = rd_addr[p][ADDR_W-1-LVL] ? node[2*n+1] : node[2*n];
            end
        end

`ifdef REGFILE_WR_BYPASS_EN
        logic bypass_hit_c;
        assign bypass_hit_c = !reset && wr_en && wr_sel[rd_addr[p]]
                              && (rd_addr[p] != ADDR_W'(ZERO_REG));
        assign rd_data[p]   = bypass_hit_c ? wr_data : node[1];
`else
        assign rd_data[p]   = node[1];
`endif
    end

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Directed self-checking bench for regfile_onehot_wr (default and REGFILE_WR_BYPASS_EN builds).
module tb_regfile_onehot_wr;
    import regfile_pkg::*;

    logic      clk;
    logic      reset;
    logic      wr_en;
    reg_sel_t  wr_sel;
    reg_data_t wr_data;
    reg_addr_t rd_addr1;
    reg_addr_t rd_addr2;
    reg_data_t rd_data1;
    reg_data_t rd_data2;

    int unsigned n_checks;
    int unsigned n_errors;

    regfile_onehot_wr dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2)
    );

    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    task automatic check(input string tag, input reg_data_t got, input reg_data_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one write for a single posedge, then return to idle on the following negedge.
    task automatic do_write(input logic en, input reg_sel_t sel, input reg_data_t data);
        @(negedge clk);
        wr_en   = en;
        wr_sel  = sel;
        wr_data = data;
        if (en && $countones(sel) > 1) begin
            $display("WARN: multi-bit wr_sel %h", sel);
        end
        @(posedge clk);
        @(negedge clk);
        wr_en  = 1'b0;
        wr_sel = '0;
    endtask

    task automatic rd1(input string tag, input reg_addr_t a, input reg_data_t exp);
        rd_addr1 = a;
        #1;
        check(tag, rd_data1, exp);
    endtask

    task automatic rd2(input string tag, input reg_addr_t a, input reg_data_t exp);
        rd_addr2 = a;
        #1;
        check(tag, rd_data2, exp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_sel   = '0;
        wr_data  = '0;
        rd_addr1 = '0;
        rd_addr2 = '0;

        // 1: reset with pre-written contents
        repeat (2) @(negedge clk);
        rd1("in_reset_x0", 5'd0, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        do_write(1'b1, 32'h0000_0020, 64'h5555_5555_5555_5555);
        do_write(1'b1, 32'h0000_0400, 64'hAAAA_AAAA_AAAA_AAAA);
        rd1("prewrite_x5", 5'd5, 64'h5555_5555_5555_5555);
        rd2("prewrite_x10", 5'd10, 64'hAAAA_AAAA_AAAA_AAAA);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_rd1", rd_data1, 64'h0);
        check("async_reset_rd2", rd_data2, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 31; i++) begin
            rd1($sformatf("post_reset_x%0d", i), reg_addr_t'(i), 64'h0);
        end

        // 2: single write
        do_write(1'b1, 32'h0000_0020, 64'hDEAD_BEEF_0000_0005);
        rd1("wr_x5", 5'd5, 64'hDEAD_BEEF_0000_0005);
        rd2("untouched_x4", 5'd4, 64'h0);

        // 3: writes to the zero register are dropped
        do_write(1'b1, 32'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        rd1("zero_reg_x31", 5'd31, 64'h0);
        rd2("zero_wr_x5_kept", 5'd5, 64'hDEAD_BEEF_0000_0005);
        rd2("zero_wr_x30_kept", 5'd30, 64'h0);

        // 4: no-write cases and multi-select write
        do_write(1'b1, 32'h0000_0008, 64'h33);
        do_write(1'b0, 32'h0000_0008, 64'h1234);
        rd1("wr_en0_x3", 5'd3, 64'h33);
        do_write(1'b1, 32'h0000_0000, 64'h1234);
        rd1("sel0_x5", 5'd5, 64'hDEAD_BEEF_0000_0005);
        do_write(1'b1, 32'h0000_0006, 64'hA5);
        rd1("multi_x1", 5'd1, 64'hA5);
        rd2("multi_x2", 5'd2, 64'hA5);
        rd1("multi_x3_kept", 5'd3, 64'h33);
        rd2("multi_x0_kept", 5'd0, 64'h0);

        // 5: same-cycle write/read hazard
        do_write(1'b1, 32'h0000_0080, 64'h10);
        @(negedge clk);
        wr_en    = 1'b1;
        wr_sel   = 32'h8000_0080;
        wr_data  = 64'h20;
        rd_addr1 = 5'd7;
        rd_addr2 = 5'd31;
        #1;
`ifdef REGFILE_WR_BYPASS_EN
        check("hazard_pre_edge", rd_data1, 64'h20);
`else
        check("hazard_pre_edge", rd_data1, 64'h10);
`endif
        check("hazard_zero_reg", rd_data2, 64'h0);
        @(posedge clk);
        #1;
        check("hazard_post_edge", rd_data1, 64'h20);
        @(negedge clk);
        wr_en  = 1'b0;
        wr_sel = '0;

        // 6: reset raised a quarter period before the write edge
        @(negedge clk);
        wr_en    = 1'b1;
        wr_sel   = 32'h0000_0200;
        wr_data  = 64'h99;
        rd_addr1 = 5'd9;
        #2;
        reset = 1'b1;
        #1;
        check("reset_gates_rd_x9", rd_data1, 64'h0);
        @(posedge clk);
        #1;
        check("reset_wins_x9", rd_data1, 64'h0);
        @(negedge clk);
        wr_en  = 1'b0;
        wr_sel = '0;
        reset  = 1'b0;
        rd1("after_reset_x9", 5'd9, 64'h0);
        rd2("after_reset_x7", 5'd7, 64'h0);
        do_write(1'b1, 32'h0000_0200, 64'h99);
        rd1("rewrite_x9", 5'd9, 64'h99);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
